// File: rtl/sig_mag_pkg.sv
// Shared constants and the sign/magnitude weighting function for the sign/mag decoder.
package sig_mag_pkg;

    localparam int NUM_MAG = 5461;   // target mag=1 count per 16384-sample window
    localparam int CNTR_W  = 14;
    localparam int SM_SIG  = 1;
    localparam int SM_MAG  = 0;
    localparam int SM_WT_W = 16;     // wide enough for any practical OUT_W; callers truncate

    typedef logic [1:0] sm_pair_t;

    // sig=0 -> +w, sig=1 -> -w, with w = mag ? mag_wt : 1
    function automatic logic signed [SM_WT_W-1:0] sm_weight(input logic sig, input logic mag,
                                                            input int mag_wt);
        logic signed [SM_WT_W-1:0] w;
        w = mag ? SM_WT_W'(mag_wt) : SM_WT_W'(1);
        return sig ? -w : w;
    endfunction

endpackage

// File: rtl/sig_mag_rate_mon.sv
// Windowed mag=1 rate monitor: counts popped samples in 2^WIN_LOG2 windows and flags out-of-band counts.
module sig_mag_rate_mon
    import sig_mag_pkg::*;
#(
    parameter int WIN_LOG2 = CNTR_W,
    parameter int MAG_LO   = NUM_MAG - NUM_MAG / 10,
    parameter int MAG_HI   = NUM_MAG + NUM_MAG / 10
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                pop,
    input  logic                mag,
    output logic [WIN_LOG2:0]   stat_cnt,
    output logic                stat_valid,
    output logic                stat_low,
    output logic                stat_high
);

    logic [WIN_LOG2-1:0] smp_q, smp_d;
    logic [WIN_LOG2:0]   mag_q, mag_d, mag_sum;
    logic [WIN_LOG2:0]   stat_cnt_q, stat_cnt_d;
    logic                stat_valid_q, stat_valid_d;
    logic                stat_low_q, stat_low_d;
    logic                stat_high_q, stat_high_d;

    always_comb begin
        smp_d        = smp_q;
        mag_d        = mag_q;
        stat_cnt_d   = stat_cnt_q;
        stat_valid_d = 1'b0;
        stat_low_d   = stat_low_q;
        stat_high_d  = stat_high_q;
        mag_sum      = mag_q + {{WIN_LOG2{1'b0}}, mag};
        if (pop) begin
            // The pop that completes the window is included in that window's count.
            if (smp_q == '1) begin
                stat_cnt_d   = mag_sum;
                stat_valid_d = 1'b1;
                stat_low_d   = mag_sum < (WIN_LOG2+1)'(MAG_LO);
                stat_high_d  = mag_sum > (WIN_LOG2+1)'(MAG_HI);
                smp_d        = '0;
                mag_d        = '0;
            end else begin
                smp_d = smp_q + 1'b1;
                mag_d = mag_sum;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            smp_q        <= '0;
            mag_q        <= '0;
            stat_cnt_q   <= '0;
            stat_valid_q <= 1'b0;
            stat_low_q   <= 1'b0;
            stat_high_q  <= 1'b0;
        end else begin
            smp_q        <= smp_d;
            mag_q        <= mag_d;
            stat_cnt_q   <= stat_cnt_d;
            stat_valid_q <= stat_valid_d;
            stat_low_q   <= stat_low_d;
            stat_high_q  <= stat_high_d;
        end
    end

    assign stat_cnt   = stat_cnt_q;
    assign stat_valid = stat_valid_q;
    assign stat_low   = stat_low_q;
    assign stat_high  = stat_high_q;

endmodule

// File: rtl/sig_mag_decoder.sv
// Unpacks 2-bit sign/mag words into one signed weighted sample per pop.
// Optional rate monitor built only when SIG_MAG_DEC_STATS_EN is defined.
module sig_mag_decoder
    import sig_mag_pkg::*;
#(
    parameter int PAIRS    = 8,
    parameter int OUT_W    = 4,
    parameter int MAG_WT   = 3,
    parameter int WIN_LOG2 = CNTR_W,
    parameter int MAG_LO   = NUM_MAG - NUM_MAG / 10,
    parameter int MAG_HI   = NUM_MAG + NUM_MAG / 10
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [2*PAIRS-1:0]        in_data,
    input  logic                      in_valid,
    output logic                      in_ready,
    output logic signed [OUT_W-1:0]   out_data,
    output logic                      out_sig,
    output logic                      out_mag,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [WIN_LOG2:0]         stat_cnt,
    output logic                      stat_valid,
    output logic                      stat_low,
    output logic                      stat_high
);

    localparam int REM_W = $clog2(PAIRS + 1);

    if ((1 << (OUT_W - 1)) <= MAG_WT) begin : g_bad_out_w
        $error("OUT_W too narrow for +/-MAG_WT");
    end
    if (MAG_LO > MAG_HI) begin : g_bad_bounds
        $error("MAG_LO must not exceed MAG_HI");
    end

    logic [2*PAIRS-1:0]      buf_q, buf_d;
    logic [REM_W-1:0]        rem_q, rem_d;
    logic signed [OUT_W-1:0] out_data_q, out_data_d;
    logic                    out_sig_q, out_sig_d;
    logic                    out_mag_q, out_mag_d;
    sm_pair_t                head;
    logic                    accept, pop;

    assign out_valid = (rem_q != '0);
    // Accepting on the last pair's pop keeps the stream bubble-free.
    assign in_ready  = (rem_q == '0) | ((rem_q == REM_W'(1)) & out_ready);
    assign accept    = in_valid & in_ready;
    assign pop       = out_valid & out_ready;

    always_comb begin
        buf_d = buf_q;
        rem_d = rem_q;
        if (accept) begin
            buf_d = in_data;
            rem_d = REM_W'(PAIRS);
        end else if (pop) begin
            buf_d = buf_q >> 2;
            rem_d = rem_q - REM_W'(1);
        end
        head       = buf_d[1:0];
        out_sig_d  = 1'b0;
        out_mag_d  = 1'b0;
        out_data_d = '0;
        if (rem_d != '0) begin
            out_sig_d  = head[SM_SIG];
            out_mag_d  = head[SM_MAG];
            out_data_d = OUT_W'(sm_weight(head[SM_SIG], head[SM_MAG], MAG_WT));
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            buf_q      <= '0;
            rem_q      <= '0;
            out_data_q <= '0;
            out_sig_q  <= 1'b0;
            out_mag_q  <= 1'b0;
        end else begin
            buf_q      <= buf_d;
            rem_q      <= rem_d;
            out_data_q <= out_data_d;
            out_sig_q  <= out_sig_d;
            out_mag_q  <= out_mag_d;
        end
    end

    assign out_data = out_data_q;
    assign out_sig  = out_sig_q;
    assign out_mag  = out_mag_q;

`ifdef SIG_MAG_DEC_STATS_EN
    sig_mag_rate_mon #(
        .WIN_LOG2 (WIN_LOG2),
        .MAG_LO   (MAG_LO),
        .MAG_HI   (MAG_HI)
    ) u_rate_mon (
        .clk        (clk),
        .reset      (reset),
        .pop        (pop),
        .mag        (out_mag_q),
        .stat_cnt   (stat_cnt),
        .stat_valid (stat_valid),
        .stat_low   (stat_low),
        .stat_high  (stat_high)
    );
`else
    assign stat_cnt   = '0;
    assign stat_valid = 1'b0;
    assign stat_low   = 1'b0;
    assign stat_high  = 1'b0;
`endif

endmodule

// File: tb/tb_sig_mag_decoder.sv
// Scoreboard bench for sig_mag_decoder with PAIRS=4; window tests run when SIG_MAG_DEC_STATS_EN is defined.
module tb_sig_mag_decoder;

    localparam int PAIRS    = 4;
    localparam int OUT_W    = 4;
    localparam int WIN_LOG2 = 14;

    logic                    clk = 1'b0;
    logic                    reset;
    logic [2*PAIRS-1:0]      in_data;
    logic                    in_valid;
    logic                    in_ready;
    logic signed [OUT_W-1:0] out_data;
    logic                    out_sig;
    logic                    out_mag;
    logic                    out_valid;
    logic                    out_ready;
    logic [WIN_LOG2:0]       stat_cnt;
    logic                    stat_valid;
    logic                    stat_low;
    logic                    stat_high;

    sig_mag_decoder #(
        .PAIRS(PAIRS), .OUT_W(OUT_W), .MAG_WT(3), .WIN_LOG2(WIN_LOG2),
        .MAG_LO(4915), .MAG_HI(6007)
    ) dut (
        .clk(clk), .reset(reset), .in_data(in_data), .in_valid(in_valid),
        .in_ready(in_ready), .out_data(out_data), .out_sig(out_sig), .out_mag(out_mag),
        .out_valid(out_valid), .out_ready(out_ready), .stat_cnt(stat_cnt),
        .stat_valid(stat_valid), .stat_low(stat_low), .stat_high(stat_high)
    );

    always #5 clk = ~clk;

    typedef struct { logic sig; logic mag; logic [3:0] data; } exp_t;
    typedef struct { logic [WIN_LOG2:0] cnt; logic lo; logic hi; } stat_t;

    exp_t  exp_q[$];
    stat_t stat_q[$];
    int    acc_cyc[$];
    int    n_cmp = 0;
    int    n_bad = 0;
    int    cyc = 0;
    int    last_pop_cyc = 0;
    int    rdy_mode = 1;      // 0: hold low, 1: hold high, 2: random
    bit    stat_nz = 1'b0;
    bit    prev_stall = 1'b0;
    logic [6:0] prev_vec;

    always @(posedge clk) cyc++;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
        n_cmp++;
        if (act !== expv) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, expv, cyc);
        end
    endtask

    // Hand table: {sig,mag} 00:+1, 01:+3, 10:-1, 11:-3 in 4-bit two's complement
    function automatic exp_t model(input logic sig, input logic mag);
        exp_t e;
        e.sig = sig;
        e.mag = mag;
        case ({sig, mag})
            2'b00:   e.data = 4'h1;
            2'b01:   e.data = 4'h3;
            2'b10:   e.data = 4'hF;
            default: e.data = 4'hD;
        endcase
        return e;
    endfunction

    function automatic logic pick_ready();
        case (rdy_mode)
            0:       return 1'b0;
            1:       return 1'b1;
            default: return 1'($urandom_range(0, 1));
        endcase
    endfunction

    task automatic send(input logic [7:0] w);
        for (int t = 0; t < 200; t++) begin
            @(negedge clk);
            out_ready = pick_ready();
            in_valid  = 1'b1;
            in_data   = w;
            #1;
            if (in_ready) begin
                for (int j = 0; j < PAIRS; j++) exp_q.push_back(model(w[2*j+1], w[2*j]));
                acc_cyc.push_back(cyc);
                return;
            end
        end
        check("send_timeout", 1, 0);
    endtask

    task automatic drain();
        for (int t = 0; t < 500; t++) begin
            @(negedge clk);
            in_valid  = 1'b0;
            out_ready = pick_ready();
            if (exp_q.size() == 0) return;
        end
        check("drain_timeout", exp_q.size(), 0);
        exp_q.delete();
    endtask

    task automatic pulse_reset();
        @(negedge clk);
        in_valid = 1'b0;
        reset = 1'b1;
        exp_q.delete();
        @(negedge clk);
        reset = 1'b0;
    endtask

    // Monitor / scoreboard, sampled just before the active edge
    always @(negedge clk) begin
        exp_t e;
        #4;
        if (reset) begin
            prev_stall = 1'b0;
        end else begin
            if (prev_stall)
                check("stall_hold", {25'd0, out_valid, out_sig, out_mag, out_data}, {25'd0, prev_vec});
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_pop", {27'd0, out_sig, out_mag, out_data}, 32'hFFFF_FFFF);
                end else begin
                    e = exp_q.pop_front();
                    check("pair", {26'd0, out_sig, out_mag, out_data}, {26'd0, e.sig, e.mag, e.data});
                end
                last_pop_cyc = cyc;
            end
            prev_stall = out_valid && !out_ready;
            prev_vec   = {out_valid, out_sig, out_mag, out_data};
        end
`ifdef SIG_MAG_DEC_STATS_EN
        if (stat_valid) stat_q.push_back('{stat_cnt, stat_low, stat_high});
`else
        if (stat_valid || stat_low || stat_high || (stat_cnt != '0)) stat_nz = 1'b1;
`endif
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

`ifdef SIG_MAG_DEC_STATS_EN
    task automatic run_window(input int n_mag, input int want_cnt, input logic want_lo,
                              input logic want_hi, input string tag);
        logic [7:0] w;
        int idx;
        stat_q.delete();
        for (int i = 0; i < (1 << WIN_LOG2) / PAIRS; i++) begin
            for (int j = 0; j < PAIRS; j++) begin
                idx = i * PAIRS + j;
                w[2*j+1] = 1'(j & 1);
                w[2*j]   = (idx < n_mag);
            end
            send(w);
        end
        drain();
        repeat (3) @(negedge clk);
        check({tag, "_pulses"}, stat_q.size(), 1);
        if (stat_q.size() > 0) begin
            check({tag, "_cnt"}, 32'(stat_q[0].cnt), want_cnt);
            check({tag, "_low"}, 32'(stat_q[0].lo), 32'(want_lo));
            check({tag, "_high"}, 32'(stat_q[0].hi), 32'(want_hi));
        end
    endtask
`endif

    initial begin
        reset     = 1'b1;
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        #1;
        check("rst_in_ready", in_ready, 1);
        check("rst_out_valid", out_valid, 0);
        check("rst_outs", {out_sig, out_mag, out_data}, 0);
        check("rst_stats", {stat_cnt, stat_valid, stat_low, stat_high}, 0);

        // single word 0xE4: +1,+3,-1,-3 on consecutive cycles
        rdy_mode = 1;
        acc_cyc.delete();
        send(8'hE4);
        drain();
        #1;
        check("t1_idle_valid", out_valid, 0);
        check("t1_span", last_pop_cyc - acc_cyc[0], PAIRS);

        // back-to-back words, no bubble
        acc_cyc.delete();
        send(8'h1B);
        send(8'hC6);
        send(8'h39);
        drain();
        check("t2_gap0", acc_cyc[1] - acc_cyc[0], PAIRS);
        check("t2_gap1", acc_cyc[2] - acc_cyc[1], PAIRS);
        check("t2_span", last_pop_cyc - acc_cyc[0], 3 * PAIRS);

        // random backpressure
        rdy_mode = 2;
        send(8'hA5);
        send(8'h5A);
        send(8'hFF);
        send(8'h00);
        send(8'h87);
        drain();

        // reset mid-word with 3 pairs left
        rdy_mode = 0;
        send(8'h9C);
        @(negedge clk);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        reset     = 1'b1;
        exp_q.delete();
        @(negedge clk);
        reset = 1'b0;
        #1;
        check("t4_valid", out_valid, 0);
        check("t4_ready", in_ready, 1);
        check("t4_data", {out_sig, out_mag, out_data}, 0);
        rdy_mode = 1;
        send(8'h72);
        drain();

`ifdef SIG_MAG_DEC_STATS_EN
        pulse_reset();
        rdy_mode = 1;
        run_window(5461, 5461, 1'b0, 1'b0, "w_nom");
        run_window(1 << WIN_LOG2, 1 << WIN_LOG2, 1'b0, 1'b1, "w_all");
        run_window(0, 0, 1'b1, 1'b0, "w_zero");
`else
        pulse_reset();
        send(8'h55);
        send(8'hAA);
        drain();
        check("stats_tied", stat_nz, 0);
`endif

        check("queue_empty", exp_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
